queen_solution_receiver: RTL and testbench

// - Consumer at the far end of the 8-queen solver's tri-state out_bus. Captures one
//   8-row board (one one-hot byte per row, row 0 first), then independently re-checks
//   it: each row one-hot, no shared column, no shared diagonal.
// - Reports pass/fail with the first offending row pair and counts valid boards.
// - Sits beside the solver datapath/controller; it is the system's self-check sink.

---
 rtl/queen_solution_receiver_pkg.sv | 27 ++
 rtl/queen_solution_receiver_onehot_to_column.sv | 21 ++
 rtl/queen_solution_receiver.sv | 151 +++++++++++++++
 tb/tb_queen_solution_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/queen_solution_receiver_pkg.sv
// Shared constants for the 8-queen solution receiver: board geometry,
// FSM state encodings, pair-walk limits and a one-hot helper.
package queen_solution_receiver_pkg;

  localparam int N_ROWS = 8;
  localparam int ROW_W  = 3;
  localparam int PTR_W  = 4;

  // row_ptr value once all eight rows have been captured
  localparam logic [PTR_W-1:0] PTR_FULL = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Pair walk runs (0,1),(0,2)..(0,7),(1,2)..(6,7)
  localparam logic [ROW_W-1:0] PAIR_I_FIRST = 3'd0;
  localparam logic [ROW_W-1:0] PAIR_J_FIRST = 3'd1;
  localparam logic [ROW_W-1:0] PAIR_I_LAST  = 3'd6;
  localparam logic [ROW_W-1:0] PAIR_J_LAST  = 3'd7;

  function automatic logic is_onehot(input logic [7:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/queen_solution_receiver_onehot_to_column.sv
// Converts one captured row byte to its queen column index and flags
// whether the byte really holds exactly one queen.
module onehot_to_column
  import queen_solution_receiver_pkg::*;
(
  input  logic [7:0]       row,
  output logic [ROW_W-1:0] col,
  output logic             onehot_ok
);

  // Priority encode; only meaningful when onehot_ok is set
  always_comb begin
    col = '0;
    for (int k = 0; k < 8; k++) begin
      if (row[k]) col = 3'(k);
    end
  end

  assign onehot_ok = is_onehot(row);

endmodule

// File: rtl/queen_solution_receiver.sv
// Self-check sink for the 8-queen solver: captures one 8-row board, then
// re-verifies it (rows one-hot, no shared column, no shared diagonal) by
// walking every row pair once, exiting early on the first failing pair.
module queen_solution_receiver
  import queen_solution_receiver_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sol_start,
  input  logic             in_valid,
  input  logic [7:0]       in_bus,
  output logic             busy,
  output logic             done,
  output logic             board_ok,
  output logic [ROW_W-1:0] fail_row_a,
  output logic [ROW_W-1:0] fail_row_b,
  output logic [CNT_W-1:0] sol_count,
  input  logic [ROW_W-1:0] rd_row,
  output logic [7:0]       rd_data
);

  logic [1:0]             state_reg;
  logic [PTR_W-1:0]       row_ptr_reg;
  logic [ROW_W-1:0]       pair_i_reg;
  logic [ROW_W-1:0]       pair_j_reg;
  logic                   onehot_err_reg;
  logic [ROW_W-1:0]       err_row_reg;
  logic                   board_ok_reg;
  logic [ROW_W-1:0]       fail_a_reg;
  logic [ROW_W-1:0]       fail_b_reg;
  logic [CNT_W-1:0]       sol_count_reg;
  logic [N_ROWS-1:0][7:0] row_mem;

  logic             start_ok;
  logic             accept;
  logic [ROW_W-1:0] wr_idx;

  // sol_start restarts capture in every state except CHECK; a beat arriving
  // together with sol_start is row 0
  assign start_ok = sol_start && (state_reg != ST_CHECK);
  assign accept   = in_valid && (start_ok || (state_reg == ST_RECV && row_ptr_reg < PTR_FULL));
  assign wr_idx   = start_ok ? '0 : row_ptr_reg[ROW_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_row
      logic [7:0] row_reg;
      // Capture this row when the accepted beat is addressed to it
      always_ff @(posedge clk) begin
        if (reset) row_reg <= '0;
        else if (accept && wr_idx == 3'(gi)) row_reg <= in_bus;
      end
      assign row_mem[gi] = row_reg;
    end
  endgenerate

  // Pair check datapath for the current (i,j)
  logic [ROW_W-1:0]  col_i, col_j;
  logic              ok_i, ok_j;
  logic signed [3:0] col_diff;
  logic [3:0]        col_abs;
  logic [3:0]        row_diff;
  logic              pair_fail;

  onehot_to_column u_col_i (.row(row_mem[pair_i_reg]), .col(col_i), .onehot_ok(ok_i));
  onehot_to_column u_col_j (.row(row_mem[pair_j_reg]), .col(col_j), .onehot_ok(ok_j));

  // 4-bit signed difference so that e.g. 0-7 does not wrap into range
  assign col_diff  = $signed({1'b0, col_i}) - $signed({1'b0, col_j});
  assign col_abs   = col_diff[3] ? 4'(-col_diff) : 4'(col_diff);
  assign row_diff  = {1'b0, pair_j_reg} - {1'b0, pair_i_reg};
  assign pair_fail = ok_i && ok_j && ((col_i == col_j) || (col_abs == row_diff));

  // Control FSM, one-hot error latch, verdict and saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      row_ptr_reg    <= '0;
      pair_i_reg     <= PAIR_I_FIRST;
      pair_j_reg     <= PAIR_J_FIRST;
      onehot_err_reg <= 1'b0;
      err_row_reg    <= '0;
      board_ok_reg   <= 1'b0;
      fail_a_reg     <= '0;
      fail_b_reg     <= '0;
      sol_count_reg  <= '0;
    end else begin
      if (state_reg == ST_DONE && board_ok_reg && sol_count_reg != '1)
        sol_count_reg <= sol_count_reg + 1'b1;

      if (start_ok) begin
        state_reg      <= ST_RECV;
        board_ok_reg   <= 1'b0;
        fail_a_reg     <= '0;
        fail_b_reg     <= '0;
        row_ptr_reg    <= in_valid ? 4'd1 : 4'd0;
        onehot_err_reg <= in_valid && !is_onehot(in_bus);
        err_row_reg    <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: state_reg <= ST_IDLE;
          ST_RECV: begin
            if (row_ptr_reg == PTR_FULL) begin
              state_reg  <= ST_CHECK;
              pair_i_reg <= PAIR_I_FIRST;
              pair_j_reg <= PAIR_J_FIRST;
            end else if (accept) begin
              row_ptr_reg <= row_ptr_reg + 4'd1;
              if (!onehot_err_reg && !is_onehot(in_bus)) begin
                onehot_err_reg <= 1'b1;
                err_row_reg    <= row_ptr_reg[ROW_W-1:0];
              end
            end
          end
          ST_CHECK: begin
            if (onehot_err_reg) begin
              state_reg  <= ST_DONE;
              fail_a_reg <= err_row_reg;
              fail_b_reg <= err_row_reg;
            end else if (pair_fail) begin
              state_reg  <= ST_DONE;
              fail_a_reg <= pair_i_reg;
              fail_b_reg <= pair_j_reg;
            end else if (pair_i_reg == PAIR_I_LAST && pair_j_reg == PAIR_J_LAST) begin
              state_reg    <= ST_DONE;
              board_ok_reg <= 1'b1;
            end else if (pair_j_reg == PAIR_J_LAST) begin
              pair_i_reg <= pair_i_reg + 3'd1;
              pair_j_reg <= pair_i_reg + 3'd2;
            end else begin
              pair_j_reg <= pair_j_reg + 3'd1;
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = (state_reg == ST_CHECK);
  assign done       = (state_reg == ST_DONE);
  assign board_ok   = board_ok_reg;
  assign fail_row_a = fail_a_reg;
  assign fail_row_b = fail_b_reg;
  assign sol_count  = sol_count_reg;
  assign rd_data    = row_mem[rd_row];

endmodule

// File: tb/tb_queen_solution_receiver.sv
// Randomized self-checking bench for queen_solution_receiver; boards are
// judged by an independent brute-force model of the 8-queen rules.
module tb_queen_solution_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       sol_start;
  logic       in_valid;
  logic [7:0] in_bus;
  logic       busy;
  logic       done;
  logic       board_ok;
  logic [2:0] fail_row_a;
  logic [2:0] fail_row_b;
  logic [7:0] sol_count;
  logic [2:0] rd_row;
  logic [7:0] rd_data;

  queen_solution_receiver #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .sol_start(sol_start), .in_valid(in_valid),
    .in_bus(in_bus), .busy(busy), .done(done), .board_ok(board_ok),
    .fail_row_a(fail_row_a), .fail_row_b(fail_row_b), .sol_count(sol_count),
    .rd_row(rd_row), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int txn = 0;
  int model_count = 0;
  logic [7:0]  board [8];
  logic [63:0] sols [3];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_board(input logic [63:0] packed_rows);
    for (int r = 0; r < 8; r++) board[r] = packed_rows[63 - 8*r -: 8];
  endtask

  // Reference: first non-one-hot row wins; otherwise scan pairs in walk order
  function automatic void model(output bit ok, output int a, output int b, output int lat);
    int cols [8];
    int k;
    for (int r = 0; r < 8; r++) begin
      int ones = 0;
      for (int c = 0; c < 8; c++) if (board[r][c]) begin ones++; cols[r] = c; end
      if (ones != 1) begin
        ok = 0; a = r; b = r; lat = 2;
        return;
      end
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        int d = cols[i] - cols[j];
        k++;
        if (d < 0) d = -d;
        if (d == 0 || d == j - i) begin
          ok = 0; a = i; b = j; lat = 1 + k;
          return;
        end
      end
    end
    ok = 1; a = 0; b = 0; lat = 29;
  endfunction

  task automatic send_board(input int gap_max, input bit start_apart, input bit junk, input string tag);
    bit ok_exp;
    int a_exp, b_exp, lat_exp, cnt;
    bit got;
    model(ok_exp, a_exp, b_exp, lat_exp);
    if (start_apart) begin
      sol_start = 1'b1; in_valid = 1'b0;
      step();
      sol_start = 1'b0;
    end
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0; sol_start = 1'b0; in_bus = 8'($urandom);
        step();
      end
      in_valid = 1'b1; in_bus = board[r]; sol_start = (r == 0) && !start_apart;
      step();
    end
    in_valid = 1'b0; sol_start = 1'b0;
    cnt = 0; got = 0;
    while (cnt < 60 && !got) begin
      step();
      cnt++;
      if (done) got = 1;
      else if (junk && busy) begin
        in_valid = 1'($urandom); sol_start = 1'($urandom); in_bus = 8'($urandom);
      end else begin
        in_valid = 1'b0; sol_start = 1'b0;
      end
    end
    in_valid = 1'b0; sol_start = 1'b0;
    check_value({tag, "_done_seen"}, 32'(got), 32'd1);
    check_value({tag, "_latency"}, cnt, lat_exp);
    check_value({tag, "_board_ok"}, 32'(board_ok), 32'(ok_exp));
    check_value({tag, "_fail_a"}, 32'(fail_row_a), a_exp);
    check_value({tag, "_fail_b"}, 32'(fail_row_b), b_exp);
    if (ok_exp && model_count != 255) model_count++;
    step();
    check_value({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_value({tag, "_ok_held"}, 32'(board_ok), 32'(ok_exp));
    check_value({tag, "_sol_count"}, 32'(sol_count), model_count);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      check_value({tag, "_rd_data"}, 32'(rd_data), 32'(board[r]));
    end
    txn++;
    $display("txn %0d %s: ok=%0d a=%0d b=%0d latency=%0d count=%0d",
             txn, tag, board_ok, fail_row_a, fail_row_b, cnt, sol_count);
  endtask

  task automatic random_board();
    int mode = int'($urandom_range(0, 3));
    int p [8];
    case (mode)
      0: set_board(sols[$urandom_range(0, 2)]);
      1: begin
        for (int r = 0; r < 8; r++) p[r] = r;
        for (int r = 7; r > 0; r--) begin
          int s = int'($urandom_range(0, r));
          int t = p[r];
          p[r] = p[s]; p[s] = t;
        end
        for (int r = 0; r < 8; r++) board[r] = 8'h01 << p[r];
      end
      2: begin
        set_board(sols[$urandom_range(0, 2)]);
        board[$urandom_range(0, 7)] = 8'($urandom);
      end
      default: for (int r = 0; r < 8; r++) board[r] = 8'h01 << $urandom_range(0, 7);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sols[0] = 64'h01_10_80_20_04_40_02_08;
    sols[1] = 64'h01_20_80_04_40_08_02_10;
    sols[2] = 64'h01_40_08_20_80_02_10_04;
    reset = 1'b1; sol_start = 1'b0; in_valid = 1'b0; in_bus = 8'h00; rd_row = 3'd0;
    repeat (3) step();
    check_value("rst_busy", 32'(busy), 0);
    check_value("rst_done", 32'(done), 0);
    check_value("rst_board_ok", 32'(board_ok), 0);
    check_value("rst_fail_a", 32'(fail_row_a), 0);
    check_value("rst_fail_b", 32'(fail_row_b), 0);
    check_value("rst_sol_count", 32'(sol_count), 0);
    check_value("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    step();

    // in_valid without sol_start must not capture anything
    in_valid = 1'b1; in_bus = 8'h5A;
    step();
    in_valid = 1'b0;
    step();
    check_value("idle_ignore_busy", 32'(busy), 0);
    check_value("idle_ignore_rd", 32'(rd_data), 0);

    set_board(sols[0]);              send_board(0, 0, 0, "clean");
    set_board(64'h01_02_04_08_10_20_40_80); send_board(0, 0, 0, "pair01");
    set_board(sols[0]); board[3] = 8'h00; send_board(0, 0, 0, "row3_zero");
    set_board(sols[0]); board[5] = 8'h11; send_board(0, 1, 0, "row5_two");
    set_board(64'h20_01_04_80_40_02_04_08); send_board(0, 0, 0, "col_2_6");
    set_board(sols[0]);              send_board(3, 0, 0, "gaps");

    // Partial board discarded by a fresh sol_start
    sol_start = 1'b1; in_valid = 1'b1; in_bus = 8'hFF;
    step();
    sol_start = 1'b0;
    repeat (3) begin in_bus = 8'($urandom); step(); end
    in_valid = 1'b0;
    set_board(sols[0]);              send_board(0, 0, 0, "partial");
    set_board(sols[1]);              send_board(1, 1, 1, "junk_check");

    repeat (40) begin
      random_board();
      send_board(2, 1'($urandom), 1'($urandom), "random");
    end

    // Reset while CHECK is running
    set_board(sols[0]);
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1; in_bus = board[r]; sol_start = (r == 0);
      step();
    end
    in_valid = 1'b0; sol_start = 1'b0;
    repeat (5) step();
    check_value("midchk_busy", 32'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_count = 0;
    check_value("midrst_busy", 32'(busy), 0);
    check_value("midrst_done", 32'(done), 0);
    check_value("midrst_board_ok", 32'(board_ok), 0);
    check_value("midrst_fail_a", 32'(fail_row_a), 0);
    check_value("midrst_fail_b", 32'(fail_row_b), 0);
    check_value("midrst_sol_count", 32'(sol_count), 0);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      check_value("midrst_rd_data", 32'(rd_data), 0);
    end
    step();

    // Drive the counter to saturation with clean boards
    set_board(sols[0]);
    while (model_count != 254) send_board(0, 0, 0, "fill");
    repeat (3) send_board(0, 0, 0, "saturate");
    check_value("sat_final", 32'(sol_count), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
